// File: rtl/dff_mem_pkg.sv
// dff_mem_pkg: shared types and helpers for the dff_mem_burst scratch store.
//   cmd_op_e  - command opcodes carried on cmd_op
//   state_e   - controller states
//   even_par  - even-parity bit of a (zero-extended) data word
package dff_mem_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CLEAR
  } state_e;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_IN_W = 64;

  function automatic logic even_par(input logic [PAR_IN_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dff_mem_array.sv
// dff_mem_array: DEPTH x WORD_W flip-flop storage.
//   clk    - write clock
//   we     - write enable, word written on the rising edge
//   waddr  - write address
//   wdata  - write word
//   raddr  - combinational read address
//   rdata  - combinational read word
// Contents are deliberately not reset.
module dff_mem_array
  import dff_mem_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dff_mem_burst.sv
// dff_mem_burst: flip-flop scratch memory with command/beat handshakes.
//   clk, rst                 - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      - command handshake (cmd_op, cmd_addr, cmd_len)
//   cmd_op                   - 00 WRITE, 01 READ, 10 CLEAR, 11 reserved (dropped)
//   cmd_len                  - beats minus one; addresses wrap modulo DEPTH
//   wr_valid/wr_ready        - write beat handshake (wr_data, err_inj)
//   rd_valid/rd_ready        - read beat handshake (rd_data, parity_err)
//   busy                     - burst in progress or read beat pending
// Build option DFF_MEM_PARITY_EN: stores an even-parity bit per word (err_inj
// inverts it on write) and reports mismatches on parity_err. Without it
// parity_err is 0 and err_inj is ignored.
module dff_mem_burst
  import dff_mem_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              err_inj,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              parity_err,
  input  logic              rd_ready,
  output logic              busy
);

`ifdef DFF_MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("dff_mem_burst: DEPTH must be a power of two and at least 2");
  end
`ifdef DFF_MEM_PARITY_EN
  if (DATA_W > PAR_IN_W) begin : g_bad_width
    $error("dff_mem_burst: DATA_W too wide for the parity helper");
  end
`endif

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_raddr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_word;
  logic              rd_word_perr;
  logic              wr_fire;

  assign cmd_ready = (state == ST_IDLE);
  assign wr_ready  = (state == ST_WRITE);
  assign busy      = (state != ST_IDLE) || rd_valid;
  assign wr_fire   = (state == ST_WRITE) && wr_valid;

  always_comb begin
    mem_we    = wr_fire || (state == ST_CLEAR);
    mem_wdata = '0;
    if (wr_fire) begin
`ifdef DFF_MEM_PARITY_EN
      mem_wdata = {even_par(PAR_IN_W'(wr_data)) ^ err_inj, wr_data};
`else
      mem_wdata = wr_data;
`endif
    end
    // In IDLE the read port looks at the incoming command so beat 0 can be
    // registered on the accept edge; elsewhere it follows ptr.
    mem_raddr = (state == ST_IDLE) ? cmd_addr : ptr;
  end

  assign rd_word = mem_rdata[DATA_W-1:0];
`ifdef DFF_MEM_PARITY_EN
  assign rd_word_perr = mem_rdata[DATA_W] ^ even_par(PAR_IN_W'(rd_word));
`else
  assign rd_word_perr = 1'b0;
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
`endif

  dff_mem_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ptr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      parity_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op_e'(cmd_op))
              OP_WRITE: begin
                ptr   <= cmd_addr;
                cnt   <= cmd_len;
                state <= ST_WRITE;
              end
              OP_CLEAR: begin
                ptr   <= cmd_addr;
                cnt   <= cmd_len;
                state <= ST_CLEAR;
              end
              OP_READ: begin
                rd_data    <= rd_word;
                parity_err <= rd_word_perr;
                rd_valid   <= 1'b1;
                ptr        <= cmd_addr + ADDR_W'(1);
                cnt        <= cmd_len;
                state      <= ST_READ;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          if (wr_valid) begin
            ptr <= ptr + ADDR_W'(1);
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - ADDR_W'(1);
          end
        end
        ST_CLEAR: begin
          ptr <= ptr + ADDR_W'(1);
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - ADDR_W'(1);
        end
        ST_READ: begin
          if (rd_ready) begin
            if (cnt == '0) begin
              rd_valid <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              rd_data    <= rd_word;
              parity_err <= rd_word_perr;
              ptr        <= ptr + ADDR_W'(1);
              cnt        <= cnt - ADDR_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_mem_burst.sv
module tb_dff_mem_burst;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          err_inj = 1'b0;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          parity_err;
  logic          rd_ready = 1'b0;
  logic          busy;

  dff_mem_burst #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .err_inj    (err_inj),
    .wr_ready   (wr_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .parity_err (parity_err),
    .rd_ready   (rd_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          p;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] model   [DEP];
  logic          model_p [DEP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a beat is consumed on the edge following a negedge
  // where rd_valid and rd_ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_unexpected: got beat %0h expected none", rd_data);
        end else begin
          e = sb.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.d));
          check("parity_err", 32'(parity_err), 32'(e.p));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int w = 0;
    while (!cmd_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len, input int nbeats,
                             input logic [DW-1:0] base, input logic [DW-1:0] step, input logic einj);
    logic [AW-1:0] a;
    do_cmd(2'b00, addr, len);
    for (int i = 0; i < nbeats; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + DW'(i) * step;
      err_inj  = einj;
      check("wr_ready", 32'(wr_ready), 32'd1);
      @(posedge clk); #1;
      a = addr + AW'(i);
      model[a] = base + DW'(i) * step;
`ifdef DFF_MEM_PARITY_EN
      model_p[a] = einj;
`else
      model_p[a] = 1'b0;
`endif
    end
    wr_valid = 1'b0;
    err_inj  = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] addr, input int len);
    exp_t e;
    logic [AW-1:0] a;
    for (int i = 0; i <= len; i++) begin
      a   = addr + AW'(i);
      e.d = model[a];
      e.p = model_p[a];
      sb.push_back(e);
    end
  endtask

  // Full-throughput read: beats leave on the len+1 edges after the accept edge.
  task automatic read_burst(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int n = 0;
    push_exp(addr, int'(len));
    rd_ready = 1'b1;
    do_cmd(2'b01, addr, len);
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("read_cycles", 32'(n), 32'(len) + 32'd1);
  endtask

  initial begin
    int  n;
    bit  pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic burst write then read-back
    write_burst(4'd3, 4'd3, 4, 8'hA1, 8'h01, 1'b0);
    read_burst(4'd3, 4'd3);
    check("busy_after_read", 32'(busy), 32'd0);

    // Wrapping burst
    write_burst(4'd14, 4'd3, 4, 8'h10, 8'h01, 1'b0);
    read_burst(4'd14, 4'd3);
    read_burst(4'd0, 4'd1);

    // Back-pressured read: beat 1 must hold while rd_ready is low
    push_exp(4'd3, 2);
    rd_ready = 1'b1;
    do_cmd(2'b01, 4'd3, 4'd2);
    for (int i = 0; i < 5; i++) begin
      rd_ready = pat[i];
      if (!pat[i]) begin
        @(negedge clk);
        check("stall_rd_data", 32'(rd_data), 32'hA2);
        check("stall_rd_valid", 32'(rd_valid), 32'd1);
        check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      @(posedge clk); #1;
    end
    check("stall_done_busy", 32'(busy), 32'd0);
    check("stall_done_cmd_ready", 32'(cmd_ready), 32'd1);

    // Fill with FF, clear the upper half
    write_burst(4'd0, 4'd15, 16, 8'hFF, 8'h00, 1'b0);
    do_cmd(2'b10, 4'd8, 4'd7);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("clear_cycles", 32'(n), 32'd8);
    for (int i = 8; i < 16; i++) begin
      model[i]   = 8'h00;
      model_p[i] = 1'b0;
    end
    read_burst(4'd0, 4'd15);

    // Reset in the middle of a write burst
    write_burst(4'd4, 4'd3, 2, 8'h55, 8'h11, 1'b0);
    check("midwr_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    read_burst(4'd4, 4'd3);

    // Reserved opcode is accepted and dropped
    do_cmd(2'b11, 4'd0, 4'd5);
    check("rsvd_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rsvd_busy", 32'(busy), 32'd0);
    check("rsvd_wr_ready", 32'(wr_ready), 32'd0);
    read_burst(4'd0, 4'd0);

    // Parity: injected error on 5A, clean word next to it
    write_burst(4'd9, 4'd0, 1, 8'h5A, 8'h00, 1'b1);
    write_burst(4'd10, 4'd0, 1, 8'h3C, 8'h00, 1'b0);
    read_burst(4'd9, 4'd1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
